// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing constants and controller state encoding for the RAM-backed FIFO.
package ram_fifo_ctrl_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = 7;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/ram_fifo_ctrl_dpram.sv
// Dual-port RAM with registered outputs; a read on a slot being written returns the old data.
module ram_fifo_ctrl_dpram
   import ram_fifo_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_a,
   input  logic              wre_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] din_a,
   output logic [DATA_W-1:0] dout_a,
   input  logic              en_b,
   input  logic              wre_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] din_b,
   output logic [DATA_W-1:0] dout_b
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array has no reset; clearing it is the controller's job, so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (en_a && wre_a) mem[addr_a] <= din_a;
      if (en_b && wre_b) mem[addr_b] <= din_b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_a <= '0;
         dout_b <= '0;
      end else begin
         if (en_a) dout_a <= mem[addr_a];
         if (en_b) dout_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// 64-entry FIFO controller over a dual-port RAM: clears the RAM after reset, then runs push/pop.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int AF_LEVEL = 56
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [CNT_W-1:0]  count,
   output logic              init_busy,
   output logic              ovf_err,
   output logic              udf_err
);

   localparam logic [CNT_W-1:0]  AF_CNT    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] init_addr;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count_next;
   logic              run;
   logic              pop_ok;
   logic              push_ok;

   logic              ram_en_a;
   logic [ADDR_W-1:0] ram_addr_a;
   logic [DATA_W-1:0] ram_din_a;
   logic [DATA_W-1:0] ram_dout_a_unused;

   assign run = (state == ST_RUN);

   // empty is checked before any same-cycle push, so a pop never bypasses into a fresh write.
   assign pop_ok  = run && rd_en && !empty;
   assign push_ok = run && wr_en && (!full || pop_ok);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok)      count_next = count + 1'b1;
      else if (pop_ok && !push_ok) count_next = count - 1'b1;
   end

   always_comb begin
      ram_en_a   = push_ok;
      ram_addr_a = wr_ptr;
      ram_din_a  = wr_data;
      if (!run) begin
         ram_en_a   = 1'b1;
         ram_addr_a = init_addr;
         ram_din_a  = '0;
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_INIT;
         init_addr   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         full        <= 1'b1;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         init_busy   <= 1'b1;
         rd_valid    <= 1'b0;
         ovf_err     <= 1'b0;
         udf_err     <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               rd_valid  <= 1'b0;
               init_addr <= init_addr + 1'b1;
               if (init_addr == LAST_ADDR) begin
                  state     <= ST_RUN;
                  init_busy <= 1'b0;
                  full      <= 1'b0;
                  empty     <= 1'b1;
               end
            end
            ST_RUN: begin
               rd_valid    <= pop_ok;
               if (push_ok) wr_ptr <= wr_ptr + 1'b1;
               if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
               count       <= count_next;
               full        <= (count_next == FULL_CNT);
               empty       <= (count_next == '0);
               almost_full <= (count_next >= AF_CNT);
               if (wr_en && full && !pop_ok) ovf_err <= 1'b1;
               if (rd_en && empty)           udf_err <= 1'b1;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   ram_fifo_ctrl_dpram u_ram (
      .clk    (clk),
      .rst    (rst),
      .en_a   (ram_en_a),
      .wre_a  (1'b1),
      .addr_a (ram_addr_a),
      .din_a  (ram_din_a),
      .dout_a (ram_dout_a_unused),
      .en_b   (pop_ok),
      .wre_b  (1'b0),
      .addr_b (rd_ptr),
      .din_b  ('0),
      .dout_b (rd_data)
   );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a queue model and a read-data scoreboard.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic [6:0] count;
   logic       init_busy;
   logic       ovf_err;
   logic       udf_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] model[$];
   logic [7:0] exp_q[$];
   bit         exp_ovf;
   bit         exp_udf;

   ram_fifo_ctrl #(.AF_LEVEL(56)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .init_busy   (init_busy),
      .ovf_err     (ovf_err),
      .udf_err     (udf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus; the model decides acceptance, the scoreboard holds the pop result.
   task automatic step(input bit wr, input logic [7:0] d, input bit rd);
      bit         pop_acc;
      bit         push_acc;
      logic [7:0] want;
      pop_acc  = rd && (model.size() > 0);
      push_acc = wr && ((model.size() < 64) || pop_acc);
      if (wr && !push_acc) exp_ovf = 1'b1;
      if (rd && !pop_acc)  exp_udf = 1'b1;
      if (pop_acc)  exp_q.push_back(model.pop_front());
      if (push_acc) model.push_back(d);
      wr_en = wr; wr_data = d; rd_en = rd;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      check("rd_valid", 32'(rd_valid), 32'(pop_acc));
      if (rd_valid && exp_q.size() > 0) begin
         want = exp_q.pop_front();
         check("rd_data", 32'(rd_data), 32'(want));
      end else begin
         exp_q.delete();
      end
      check("count", 32'(count), 32'(model.size()));
      check("full", 32'(full), 32'(model.size() == 64));
      check("empty", 32'(empty), 32'(model.size() == 0));
      check("almost_full", 32'(almost_full), 32'(model.size() >= 56));
      check("ovf_err", 32'(ovf_err), 32'(exp_ovf));
      check("udf_err", 32'(udf_err), 32'(exp_udf));
   endtask

   task automatic do_reset();
      int cyc;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_count", 32'(count), 0);
      check("rst_full", 32'(full), 1);
      check("rst_empty", 32'(empty), 1);
      check("rst_init_busy", 32'(init_busy), 1);
      check("rst_af", 32'(almost_full), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_ovf", 32'(ovf_err), 0);
      check("rst_udf", 32'(udf_err), 0);
      rst = 1'b0;
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      cyc = 0;
      while (init_busy && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (init_busy) begin
            check("init_full", 32'(full), 1);
            check("init_empty", 32'(empty), 1);
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
      check("init_cycles", 32'(cyc), 64);
      check("run_count", 32'(count), 0);
      check("run_empty", 32'(empty), 1);
      check("run_full", 32'(full), 0);
      check("init_ovf", 32'(ovf_err), 0);
      check("init_udf", 32'(udf_err), 0);
      model.delete();
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
   endtask

   initial begin
      int bad;
      do_reset();

      // Three pushes then three pops.
      step(1, 8'h22, 0);
      step(1, 8'h45, 0);
      step(1, 8'h34, 0);
      repeat (3) step(0, 8'h00, 1);

      // Fill to 64, overflow attempt, drain in order.
      for (int i = 0; i < 64; i++) step(1, 8'(i), 0);
      step(1, 8'hAA, 0);
      for (int i = 0; i < 64; i++) step(0, 8'h00, 1);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 64; i++) step(1, 8'(8'h80 + i), 0);
      step(1, 8'h77, 1);
      for (int i = 0; i < 64; i++) step(0, 8'h00, 1);

      // Reset with RAM holding data: the clear sequence must zero every slot.
      do_reset();
      bad = 0;
      for (int a = 0; a < 64; a++) if (dut.u_ram.mem[a] !== 8'h00) bad++;
      check("backdoor_zero", 32'(bad), 0);

      // Pop on empty, then push plus pop on empty.
      step(0, 8'h00, 1);
      step(1, 8'h11, 1);
      step(0, 8'h00, 1);

      // Random interleave across pointer wrap with an asynchronous reset mid-stream.
      for (int i = 0; i < 200; i++) begin
         if (i == 100) begin
            #3 rst = 1'b1;
            #1;
            check("async_count", 32'(count), 0);
            check("async_empty", 32'(empty), 1);
            check("async_busy", 32'(init_busy), 1);
            @(negedge clk);
            do_reset();
         end
         step(1'($urandom_range(0, 1)), 8'(i), 1'($urandom_range(0, 1)));
      end
      while (model.size() > 0) step(0, 8'h00, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
